// File: rtl/elastic_pipe.sv
// Elastic register chain of STAGES valid/ready slots; STAGES cycles input to output, 1 payload/cycle.
// Backpressure ripples combinationally through full slots; stall freezes everything, flush kills masked slots.
module elastic_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 3,
  parameter int PERF_W = 16,
  localparam int OCC_W = $clog2(STAGES + 1)
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  input  logic              stall,
  input  logic              flush,
  input  logic [STAGES-1:0] flush_mask,
  output logic [OCC_W-1:0]  occupancy,
  output logic [PERF_W-1:0] stall_cnt,
  output logic [PERF_W-1:0] bubble_cnt
);

  generate
    if (STAGES < 1 || STAGES > 8) begin : g_bad_stages
      $error("elastic_pipe: STAGES must be in 1..8");
    end
  endgenerate

  logic [STAGES-1:0] v;
  logic [STAGES-1:0] v_nxt;
  logic [STAGES-1:0] xin;
  logic [STAGES:0]   rdy;
  logic [WIDTH-1:0]  d [STAGES];

  // A slot is ready if it, or any slot downstream of it, is empty.
  always_comb begin
    rdy = '0;
    rdy[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      rdy[k] = !v[k] || rdy[k+1];
    end
  end

  assign in_ready  = rdy[0] && !stall;
  assign out_valid = v[STAGES-1] && !stall;
  assign out_data  = d[STAGES-1];

  always_comb begin
    xin    = '0;
    v_nxt  = v;
    xin[0] = in_valid && in_ready;
    for (int k = 1; k < STAGES; k++) begin
      xin[k] = v[k-1] && rdy[k] && !stall;
    end
    for (int k = 0; k < STAGES; k++) begin
      if (flush && flush_mask[k]) begin
        v_nxt[k] = 1'b0;
      end else if (xin[k]) begin
        v_nxt[k] = 1'b1;
      end else if (rdy[k+1] && !stall) begin
        v_nxt[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      v <= '0;
      for (int k = 0; k < STAGES; k++) begin
        d[k] <= '0;
      end
    end else begin
      v <= v_nxt;
      if (xin[0]) begin
        d[0] <= in_data;
      end
      for (int k = 1; k < STAGES; k++) begin
        if (xin[k]) begin
          d[k] <= d[k-1];
        end
      end
    end
  end

  always_comb begin
    occupancy = '0;
    for (int k = 0; k < STAGES; k++) begin
      occupancy = occupancy + OCC_W'(v[k]);
    end
  end

  // Saturating counters: hold at all-ones rather than wrap.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (stall && !(&stall_cnt)) begin
        stall_cnt <= stall_cnt + PERF_W'(1);
      end
      if (out_ready && !v[STAGES-1] && !stall && !(&bubble_cnt)) begin
        bubble_cnt <= bubble_cnt + PERF_W'(1);
      end
    end
  end

endmodule
